// File: rtl/pll_reset_supervisor.sv
// PLL reset sequencer and system-reset qualifier running in the refclk domain.
// Optional lock-timeout retry in WAIT_LOCK is enabled by defining PLL_SUP_TIMEOUT_EN.
module pll_reset_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int unsigned MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned MAX_C = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int unsigned CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
`ifdef PLL_SUP_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          cnt_inc;
  logic          sync1, lk;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_inc = 1'b0;
    case (state)
      ST_PLL_RST: begin
        cnt_inc = 1'b1;
        if (cnt == RST_LAST) state_n = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lk) begin
          state_n = ST_STABLE;
        end
`ifdef PLL_SUP_TIMEOUT_EN
        else begin
          cnt_inc = 1'b1;
          if (cnt == TIMEOUT_LAST) state_n = ST_PLL_RST;
        end
`endif
      end
      ST_STABLE: begin
        // A lock drop takes priority over the final qualification count.
        if (!lk) begin
          state_n = ST_WAIT_LOCK;
        end else begin
          cnt_inc = 1'b1;
          if (cnt == STABLE_LAST) state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lk) state_n = ST_PLL_RST;
      end
      default: state_n = ST_PLL_RST;
    endcase

    if (state_n != state) cnt_n = '0;
    else if (cnt_inc)     cnt_n = cnt + 1'b1;
    else                  cnt_n = cnt;
  end

  // Outputs are registered from the next state so they change glitch-free with it.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state    <= ST_PLL_RST;
      cnt      <= '0;
      pll_rst  <= 1'b1;
      sys_rst  <= 1'b1;
      ready    <= 1'b0;
      loss_cnt <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pll_rst <= (state_n == ST_PLL_RST);
      sys_rst <= (state_n != ST_RUN);
      ready   <= (state_n == ST_RUN);
      if (state == ST_RUN && state_n == ST_PLL_RST && loss_cnt != '1)
        loss_cnt <= loss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Scoreboard bench for pll_reset_supervisor: a lock-history reference model queues
// the expected outputs each edge; a negedge monitor pops and compares.
module tb_pll_reset_supervisor;

  localparam int unsigned RST_C  = 4;
  localparam int unsigned STAB_C = 8;
  localparam int unsigned TOUT_C = 20;
  localparam int unsigned CW     = 8;
  localparam int          LOSS_MAX = (1 << CW) - 1;

  logic          refclk;
  logic          rst;
  logic          pll_locked;
  logic          pll_rst;
  logic          sys_rst;
  logic          ready;
  logic [CW-1:0] loss_cnt;

  pll_reset_supervisor #(
    .RST_CYCLES   (RST_C),
    .STABLE_CYCLES(STAB_C),
    .LOCK_TIMEOUT (TOUT_C),
    .CNT_W        (CW)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_rst   (sys_rst),
    .ready     (ready),
    .loss_cnt  (loss_cnt)
  );

  typedef struct packed {
    logic          pll_rst;
    logic          sys_rst;
    logic          ready;
    logic [CW-1:0] loss;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   started = 0;

  // Reference model: lock history expressed as a reset-pulse budget, a lock streak
  // length and an idle-wait length, rather than as an explicit state machine.
  int m_s1, m_lk, lk_now;
  int pulse_left, streak, wait_edges, loss;
  bit running;

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  always @(posedge refclk or posedge rst) begin
    started = 1;
    if (rst) begin
      m_s1 = 0; m_lk = 0;
      pulse_left = RST_C; streak = 0; wait_edges = 0;
      running = 0; loss = 0;
      q.delete();
    end else begin
      lk_now = m_lk;
      m_lk   = m_s1;
      m_s1   = int'(pll_locked);
      if (pulse_left > 0) begin
        pulse_left--;
      end else if (running) begin
        if (lk_now == 0) begin
          running = 0;
          pulse_left = RST_C;
          streak = 0; wait_edges = 0;
          if (loss < LOSS_MAX) loss++;
        end
      end else if (lk_now == 1) begin
        // first lock edge starts qualification, then STAB_C more locked edges release
        streak++;
        wait_edges = 0;
        if (streak == STAB_C + 1) begin
          running = 1;
          streak = 0;
        end
      end else if (streak > 0) begin
        streak = 0;
        wait_edges = 0;
      end else begin
        wait_edges++;
`ifdef PLL_SUP_TIMEOUT_EN
        if (wait_edges == TOUT_C) begin
          pulse_left = RST_C;
          wait_edges = 0;
        end
`endif
      end
    end
    q.push_back('{pll_rst: (pulse_left > 0), sys_rst: !running, ready: running,
                  loss: CW'(loss)});
  end

  always @(negedge refclk) begin
    exp_t e;
    cyc++;
    if (q.size() == 0) begin
      if (started) begin
        tests++; fails++;
        $display("FAIL cyc%0d queue: no expected entry available", cyc);
      end
    end else begin
      e = q.pop_front();
      tests++;
      if (pll_rst !== e.pll_rst || sys_rst !== e.sys_rst || ready !== e.ready ||
          loss_cnt !== e.loss) begin
        fails++;
        $display("FAIL cyc%0d outputs: got pll_rst=%b sys_rst=%b ready=%b loss=%0d, expected pll_rst=%b sys_rst=%b ready=%b loss=%0d",
                 cyc, pll_rst, sys_rst, ready, loss_cnt, e.pll_rst, e.sys_rst, e.ready, e.loss);
      end
    end
  end

  task automatic hold(input logic v, input int n);
    pll_locked = v;
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic pulse_rst();
    @(posedge refclk);
    #2 rst = 1'b1;
    repeat (2) @(posedge refclk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) @(posedge refclk);
    #1 rst = 1'b0;

    hold(1'b0, 14);               // single PLL reset pulse, then waiting
    hold(1'b1, 20);               // qualify and release
    hold(1'b0, 3);                // loss in RUN
    hold(1'b1, 25);
    hold(1'b0, 30);               // loss, then long wait
    hold(1'b1, 8);                // into STABLE around count 5
    hold(1'b0, 3);                // glitch restarts qualification
    hold(1'b1, 20);

    for (int i = 0; i < 300; i++) begin
      hold(1'b0, $urandom_range(3, 1));
      hold(1'b1, $urandom_range(24, 18));
    end

    hold(1'b0, 60);               // timeout retry pattern when enabled

    hold(1'b1, 8);                // mid-STABLE reset
    pulse_rst();
    hold(1'b0, 10);
    hold(1'b1, 25);               // mid-RUN reset
    pulse_rst();
    hold(1'b1, 25);

    for (int i = 0; i < 80; i++) begin
      hold(1'($urandom_range(1, 0)), $urandom_range(40, 1));
      if (i % 16 == 15) pulse_rst();
    end

    repeat (3) @(negedge refclk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
